secded_decoder_pipe: RTL and testbench
======================================

SECDED_DECODER_PIPE -- requirements
Module: secded_decoder_pipe

Interface
REQ-001 Parameter DATA_W, default 64: data bits per codeword; legal range 8..128.
REQ-002 Parameter CHECK_W, default 8: Hamming check bits plus one overall parity bit; SHALL satisfy 2^(CHECK_W-1) >= DATA_W+CHECK_W.
REQ-003 Parameter CNT_W, default 16: width of each error counter.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: in_data holds a codeword.
REQ-007 Port in_ready, output, 1: block accepts the codeword this cycle.
REQ-008 Port in_data, input, DATA_W+CHECK_W: {check[CHECK_W-1:0], data[DATA_W-1:0]}.
REQ-009 Port out_valid, output, 1: decoded result present.
REQ-010 Port out_ready, input, 1: consumer accepts the result this cycle.
REQ-011 Port out_data, output, DATA_W: corrected data.
REQ-012 Port out_single, output, 1: corrected single-bit error.
REQ-013 Port out_double, output, 1: uncorrectable error.
REQ-014 Port out_syndrome, output, CHECK_W: {overall mismatch p, Hamming syndrome s[CHECK_W-2:0]}.
REQ-015 Ports cnt_clr (input, 1), sec_cnt (output, CNT_W), ded_cnt (output, CNT_W): present only under ERR_CNT (see Configuration).

Function
REQ-016 Code SHALL map data bits in ascending order onto the non-power-of-two Hamming positions 3,5,6,7,9,...; check[i] for i<CHECK_W-1 SHALL sit at position 2^i and cover the positions whose bit i is set.
REQ-017 check[CHECK_W-1] SHALL be the even overall parity of all data bits and check[CHECK_W-2:0].
REQ-018 Stage 1 SHALL register data, s = recomputed check XOR received check, and p = XOR of the whole codeword.
REQ-019 Stage 2 SHALL register classification and correction.
REQ-020 Classification: s=0,p=0 -> clean; p=1 and s a valid position (0, power of two, or a data position) -> single; s!=0,p=0 -> double; p=1 with s beyond the last position -> double.
REQ-021 On single with s at a data position, that data bit SHALL be flipped; on a check-bit or parity-bit error, data SHALL pass unchanged.
REQ-022 On double, out_data SHALL equal the received data, uncorrected.
REQ-023 out_single and out_double SHALL never both be 1.
REQ-024 Latency SHALL be 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-025 Throughput SHALL be 1 word per cycle.
REQ-026 Each stage SHALL hold its contents while the downstream stage is full and not accepting.
REQ-027 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances this cycle; no word is dropped or duplicated.
REQ-028 out_data, out_single, out_double and out_syndrome SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 In the cycle after rst=1, out_valid, out_data, out_single, out_double, out_syndrome, sec_cnt and ded_cnt SHALL be 0, and both stages SHALL be empty.
REQ-030 Words in flight when rst asserts SHALL be discarded; in_ready SHALL be 0 while rst=1.

Configuration
REQ-031 Macro SECDED_DECODER_PIPE_ERR_CNT_EN defined: cnt_clr, sec_cnt and ded_cnt SHALL exist.
REQ-032 With the macro defined, sec_cnt/ded_cnt SHALL increment on each output handshake carrying out_single/out_double.
REQ-033 With the macro defined, the counters SHALL saturate at 2^CNT_W-1.
REQ-034 With the macro defined, cnt_clr SHALL zero both counters next cycle and win over a simultaneous increment.
REQ-035 Macro undefined: those ports and all counter logic SHALL be absent; datapath behaviour is identical.

Verification
REQ-036 Clean word: data 64'h0123_4567_89AB_CDEF with correct check, out_ready=1 -> out_valid 2 cycles later; same data; single=0, double=0, syndrome=0.
REQ-037 Flip data bit 0 -> s=3, p=1; out_single=1; data corrected; sec_cnt 0->1.
REQ-038 Flip data bits 0 and 1 -> out_double=1; data uncorrected; ded_cnt 0->1.
REQ-039 Flip check[7] only -> syndrome=8'h80; out_single=1; data unchanged.
REQ-040 Back-to-back stream of 10 words with out_ready low for cycles 3-5 -> all 10 words delivered in order; none lost or duplicated; in_ready drops once both stages are full.
REQ-041 Counter drive: sec_cnt preloaded to 16'hFFFF plus one more single -> stays 16'hFFFF; cnt_clr with a simultaneous single -> 0; rst mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready flow control.
// Define SECDED_DECODER_PIPE_ERR_CNT_EN to add cnt_clr/sec_cnt/ded_cnt error counters.
module secded_decoder_pipe #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHECK_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W+CHECK_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_single,
    output logic                      out_double,
    output logic [CHECK_W-1:0]        out_syndrome
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
    ,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          sec_cnt,
    output logic [CNT_W-1:0]          ded_cnt
`endif
);
    localparam int unsigned H_W  = CHECK_W - 1;
    localparam int unsigned NPOS = 1 << H_W;

    typedef logic [H_W-1:0]    pos_t;
    typedef pos_t [DATA_W-1:0] pos_tab_t;

    // Hamming position of each data bit: ascending non-power-of-two positions from 3.
    function automatic pos_tab_t build_pos_tab();
        pos_tab_t    tab;
        int unsigned idx;
        tab = '0;
        idx = 0;
        for (int unsigned p = 3; p < NPOS; p++) begin
            if ((p & (p - 1)) != 0 && idx < DATA_W) begin
                tab[idx] = pos_t'(p);
                idx++;
            end
        end
        return tab;
    endfunction

    localparam pos_tab_t POS = build_pos_tab();

    logic               s1_valid_q;
    logic [DATA_W-1:0]  s1_data_q;
    pos_t               s1_syn_q, s1_syn_d;
    logic               s1_par_q, s1_par_d;

    logic               s2_valid_q;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d;
    logic               s2_single_q, s2_single_d;
    logic               s2_double_q, s2_double_d;
    logic [CHECK_W-1:0] s2_syn_q;

    logic               s2_take;
    logic               s1_open;

    assign s2_take  = !s2_valid_q || out_ready;
    assign s1_open  = !s1_valid_q || s2_take;
    assign in_ready = !rst && s1_open;

    always_comb begin
        pos_t calc;
        calc = '0;
        for (int unsigned i = 0; i < H_W; i++) begin
            for (int unsigned j = 0; j < DATA_W; j++) begin
                if (POS[j][i]) calc[i] = calc[i] ^ in_data[j];
            end
        end
        s1_syn_d = calc ^ in_data[DATA_W +: H_W];
        s1_par_d = ^in_data;
    end

    // Any syndrome up to the last data position is a real position; powers of two are check bits.
    always_comb begin
        logic valid_pos;
        valid_pos   = ((s1_syn_q & (s1_syn_q - pos_t'(1))) == '0) ||
                      (s1_syn_q <= POS[DATA_W-1]);
        s2_single_d = s1_par_q && valid_pos;
        s2_double_d = (s1_par_q && !valid_pos) || (!s1_par_q && (s1_syn_q != '0));
        s2_data_d   = s1_data_q;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (s2_single_d && (s1_syn_q == POS[j])) s2_data_d[j] = ~s1_data_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_single_q <= 1'b0;
            s2_double_q <= 1'b0;
            s2_syn_q    <= '0;
        end else begin
            if (s1_open) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= in_data[DATA_W-1:0];
                    s1_syn_q  <= s1_syn_d;
                    s1_par_q  <= s1_par_d;
                end
            end
            if (s2_take) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q   <= s2_data_d;
                    s2_single_q <= s2_single_d;
                    s2_double_q <= s2_double_d;
                    s2_syn_q    <= {s1_par_q, s1_syn_q};
                end
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = s2_data_q;
    assign out_single   = s2_single_q;
    assign out_double   = s2_double_q;
    assign out_syndrome = s2_syn_q;

`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t sec_cnt_q, sec_cnt_d;
    cnt_t ded_cnt_q, ded_cnt_d;
    logic out_fire;

    always_comb begin
        out_fire  = s2_valid_q && out_ready;
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else begin
            if (out_fire && s2_single_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + cnt_t'(1);
            if (out_fire && s2_double_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    assign sec_cnt = sec_cnt_q;
    assign ded_cnt = ded_cnt_q;
`endif

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Self-checking bench for secded_decoder_pipe; reference model computes the syndrome as
// the XOR of the Hamming positions of all set codeword bits.
module tb_secded_decoder_pipe;
    localparam int DW       = 64;
    localparam int CW       = 8;
    localparam int NW       = DW + CW;
    localparam int TB_CNT_W = 8;

    typedef logic [CW-2:0] h_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          single;
        logic          dbl;
        logic [CW-1:0] syn;
    } res_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [NW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_single;
    logic          out_double;
    logic [CW-1:0] out_syndrome;
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
    logic                cnt_clr = 1'b0;
    logic [TB_CNT_W-1:0] sec_cnt;
    logic [TB_CNT_W-1:0] ded_cnt;
`endif

    int          compared   = 0;
    int          mismatched = 0;
    int unsigned pos_tb [DW];
    res_t        sb [$];

    always #5 clk = ~clk;

    secded_decoder_pipe #(.DATA_W(DW), .CHECK_W(CW), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_single   (out_single),
        .out_double   (out_double),
        .out_syndrome (out_syndrome)
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .sec_cnt      (sec_cnt),
        .ded_cnt      (ded_cnt)
`endif
    );

    function automatic bit is_check_pos(input int unsigned x);
        for (int i = 0; i < 32; i++) if (x == (32'd1 << i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [NW-1:0] encode(input logic [DW-1:0] d);
        int unsigned s;
        h_t          chk;
        s = 0;
        for (int j = 0; j < DW; j++) if (d[j]) s = s ^ pos_tb[j];
        chk = h_t'(s);
        return {(^d) ^ (^chk), chk, d};
    endfunction

    function automatic res_t model(input logic [NW-1:0] cw);
        res_t        r;
        int unsigned s;
        logic        p;
        logic        valid;
        s = 0;
        for (int j = 0; j < DW; j++) if (cw[j]) s = s ^ pos_tb[j];
        for (int i = 0; i < CW - 1; i++) if (cw[DW+i]) s = s ^ (32'd1 << i);
        p     = ^cw;
        valid = (s == 0) || is_check_pos(s);
        for (int j = 0; j < DW; j++) if (pos_tb[j] == s) valid = 1'b1;
        r.data   = cw[DW-1:0];
        r.single = p && valid;
        r.dbl    = ((s != 0) || p) && !r.single;
        if (r.single) begin
            for (int j = 0; j < DW; j++) if (pos_tb[j] == s) r.data[j] = ~r.data[j];
        end
        r.syn = {p, h_t'(s)};
        return r;
    endfunction

    function automatic logic [NW-1:0] corrupt(input logic [NW-1:0] cw, input int unsigned mode);
        logic [NW-1:0] w;
        int unsigned   a;
        int unsigned   b;
        int unsigned   c;
        w = cw;
        a = $urandom_range(0, NW - 1);
        b = (a + 1 + $urandom_range(0, NW - 3)) % NW;
        c = (a + NW - 1) % NW;
        case (mode)
            1: w[a] = ~w[a];
            2: begin w[a] = ~w[a]; w[b] = ~w[b]; end
            3: begin w[a] = ~w[a]; w[b] = ~w[b]; w[c] = ~w[c]; end
            4: w[a % DW] = ~w[a % DW];
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = encode(rand64()); out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++; if ({out_data, out_single, out_double, out_syndrome} !== '0)
            begin mismatched++; $display("FAIL reset_outputs: got %h/%b/%b/%h want 0", out_data, out_single, out_double, out_syndrome); end
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
        compared++; if ({sec_cnt, ded_cnt} !== '0) begin mismatched++; $display("FAIL reset_counters: got %h/%h want 0", sec_cnt, ded_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [DW-1:0] base;
        logic [NW-1:0] flip     [4];
        logic [CW-1:0] exp_syn  [4];
        logic          exp_s    [4];
        logic          exp_d    [4];
        logic [DW-1:0] exp_data [4];
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
        logic [TB_CNT_W-1:0] exp_sec = '0;
        logic [TB_CNT_W-1:0] exp_ded = '0;
`endif
        base = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) flip[i] = '0;
        flip[1][0] = 1'b1;
        flip[2][1:0] = 2'b11;
        flip[3][NW-1] = 1'b1;
        exp_syn  = '{8'h00, 8'h83, 8'h06, 8'h80};
        exp_s    = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_d    = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_data = '{base, base, base ^ 64'h3, base};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = encode(base) ^ flip[i]; out_ready = 1'b1; #1;
            compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL dir%0d_accept: got %b want 1", i, in_ready); end
            @(negedge clk); in_valid = 1'b0; #1;
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL dir%0d_early: got out_valid %b want 0", i, out_valid); end
            @(negedge clk); #1;
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL dir%0d_latency: got out_valid %b want 1", i, out_valid); end
            compared++;
            if (out_data !== exp_data[i] || out_single !== exp_s[i] || out_double !== exp_d[i] || out_syndrome !== exp_syn[i]) begin
                mismatched++;
                $display("FAIL dir%0d_result: got %h s%b d%b syn %h want %h s%b d%b syn %h", i, out_data, out_single,
                         out_double, out_syndrome, exp_data[i], exp_s[i], exp_d[i], exp_syn[i]);
            end
            @(negedge clk); #1;
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
            exp_sec = exp_sec + {{(TB_CNT_W-1){1'b0}}, exp_s[i]};
            exp_ded = exp_ded + {{(TB_CNT_W-1){1'b0}}, exp_d[i]};
            compared++; if (sec_cnt !== exp_sec || ded_cnt !== exp_ded)
                begin mismatched++; $display("FAIL dir%0d_counts: got %0d/%0d want %0d/%0d", i, sec_cnt, ded_cnt, exp_sec, exp_ded); end
`endif
        end
    endtask

    task automatic test_random(input int n);
        res_t exp;
        res_t held;
        logic held_v;
        held_v = 1'b0;
        held   = '0;
        for (int c = 0; c < n + 30; c++) begin
            if (c >= n && sb.size() == 0) break;
            @(negedge clk);
            in_valid  = (c < n) && ($urandom_range(0, 3) != 0);
            in_data   = corrupt(encode(rand64()), $urandom_range(0, 4));
            out_ready = (c >= n) || ($urandom_range(0, 3) != 0);
            #1;
            if (held_v) begin
                compared++;
                if (out_valid !== 1'b1 || {out_data, out_single, out_double, out_syndrome} !== held) begin
                    mismatched++;
                    $display("FAIL rand_stall_hold: got v%b %h want v1 %h", out_valid, {out_data, out_single, out_double, out_syndrome}, held);
                end
            end
            if (out_valid && out_ready) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++; $display("FAIL rand_extra_output: got %h want none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if ({out_data, out_single, out_double, out_syndrome} !== exp || (out_single && out_double)) begin
                        mismatched++;
                        $display("FAIL rand_result: got %h s%b d%b syn %h want %h s%b d%b syn %h", out_data, out_single,
                                 out_double, out_syndrome, exp.data, exp.single, exp.dbl, exp.syn);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_data));
            held_v = out_valid && !out_ready;
            held   = {out_data, out_single, out_double, out_syndrome};
        end
        in_valid = 1'b0;
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL rand_drain: got %0d pending want 0", sb.size()); end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [10];
        int            next_in;
        int            got;
        int            c;
        for (int i = 0; i < 10; i++) words[i] = rand64();
        next_in = 0; got = 0; c = 0;
        while (got < 10 && c < 40) begin
            @(negedge clk);
            in_valid  = (next_in < 10);
            in_data   = (next_in < 10) ? corrupt(encode(words[next_in]), (next_in % 2 == 1) ? 1 : 0) : '0;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c == 2) begin
                compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_c2: got %b want 1", in_ready); end
            end
            if (c == 3) begin
                compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_full_block: got %b want 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                compared++;
                if (out_data !== words[got]) begin mismatched++; $display("FAIL b2b_order%0d: got %h want %h", got, out_data, words[got]); end
                got++;
            end
            if (in_valid && in_ready) next_in++;
            c++;
        end
        in_valid = 1'b0;
        compared++; if (got != 10) begin mismatched++; $display("FAIL b2b_count: got %0d want 10", got); end
        @(negedge clk); #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_duplicate: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_valid = 1'b1; in_data = encode(rand64());
        end
        @(negedge clk); rst = 1'b1; in_data = encode(rand64()); #1;
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0; #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_flush: got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_stale%0d: got %b want 0", i, out_valid); end
        end
        d = rand64();
        @(negedge clk); in_valid = 1'b1; in_data = encode(d);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        compared++; if (out_valid !== 1'b1 || out_data !== d)
            begin mismatched++; $display("FAIL mid_rst_resume: got v%b %h want v1 %h", out_valid, out_data, d); end
        @(negedge clk);
    endtask

`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
    task automatic test_counters();
        int sent;
        int got;
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; #1;
        compared++; if ({sec_cnt, ded_cnt} !== '0) begin mismatched++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", sec_cnt, ded_cnt); end
        sent = 0; got = 0;
        for (int c = 0; c < 600 && got < 260; c++) begin
            @(negedge clk);
            in_valid = (sent < 260); in_data = corrupt(encode(rand64()), 4); out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        compared++; if (got != 260) begin mismatched++; $display("FAIL cnt_stream: got %0d words want 260", got); end
        compared++; if (sec_cnt !== 8'hFF || ded_cnt !== 8'h00)
            begin mismatched++; $display("FAIL cnt_saturate: got %0d/%0d want 255/0", sec_cnt, ded_cnt); end
        @(negedge clk); in_valid = 1'b1; in_data = corrupt(encode(rand64()), 4);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); cnt_clr = 1'b1; #1;
        compared++; if (out_valid !== 1'b1 || out_single !== 1'b1)
            begin mismatched++; $display("FAIL cnt_clr_word: got v%b s%b want v1 s1", out_valid, out_single); end
        @(negedge clk); cnt_clr = 1'b0; #1;
        compared++; if (sec_cnt !== '0) begin mismatched++; $display("FAIL cnt_clr_wins: got %0d want 0", sec_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        k = 0;
        for (int unsigned q = 3; k < DW; q++) begin
            if (!is_check_pos(q)) begin pos_tb[k] = q; k++; end
        end
        test_reset();
        test_directed();
        test_random(400);
        test_back_to_back();
        test_reset_midstream();
`ifdef SECDED_DECODER_PIPE_ERR_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
